word_fetch_requester: RTL

Requesting end of the ROM word-fetch interface. On a game-round start it pulses Read3 with a word index on Count, waits for Valid, and captures the 64-bit WordOut (8 ASCII characters, byte 7 = first character). It then streams the characters one at a time to the display/compare logic over a valid/ready handshake, and reports word length and completion. It sits between the game controller FSM and the ROM word reader.

---
 rtl/word_fetch_requester.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/word_fetch_requester.sv
`default_nettype none
// ============================================================================
// word_fetch_requester: fetches a ROM word, then streams its 8 characters out.
// Revision 1.0
// ============================================================================

module word_fetch_requester #(
  parameter int NUM_WORDS = 32,
  parameter int TIMEOUT   = 16,
  parameter int RETRIES   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [63:0] WordOut,
  input  logic        Valid,
  output logic        Read3,
  output logic [4:0]  Count,
  output logic [7:0]  CharOut,
  output logic        CharValid,
  input  logic        CharReady,
  output logic [2:0]  CharIdx,
  output logic [3:0]  WordLen,
  output logic        Done,
  output logic        Error
);

  localparam int c_TW = $clog2(TIMEOUT);
  localparam int c_RW = $clog2(RETRIES + 2);
  localparam logic [c_TW-1:0] c_TMO_LAST  = c_TW'(TIMEOUT - 1);
  localparam logic [c_RW-1:0] c_RETRY_MAX = c_RW'(RETRIES);
  localparam logic [4:0]      c_CNT_LAST  = 5'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [63:0]     r_word;
  logic [4:0]      r_count;
  logic [2:0]      r_idx;
  logic [3:0]      r_len;
  logic [c_TW-1:0] r_tmo;
  logic [c_RW-1:0] r_retry;

  logic            w_tmo_hit;
  logic            w_last_xfer;
  logic [63:0]     w_shifted;
  logic [3:0]      w_len;
  logic            w_found;

  assign w_tmo_hit   = (r_tmo == c_TMO_LAST);
  assign w_last_xfer = (r_state == S_STREAM) && CharReady && (r_idx == 3'd7);

  // Character under the index is brought to the top byte.
  assign w_shifted = r_word << {r_idx, 3'b000};

  assign Count   = r_count;
  assign CharIdx = r_idx;
  assign WordLen = r_len;
  assign CharOut = CharValid ? w_shifted[63:56] : 8'h00;

  always_comb begin
    w_len   = 4'd8;
    w_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!w_found && ((WordOut[63-8*i -: 8] == 8'h20) || (WordOut[63-8*i -: 8] == 8'h00))) begin
        w_len   = 4'(i);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    Read3     = 1'b0;
    CharValid = 1'b0;
    Done      = 1'b0;
    Error     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Start) w_next = S_REQ;
      end
      S_REQ: begin
        Read3  = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        if (Valid) begin
          w_next = S_STREAM;
        end else if (w_tmo_hit) begin
          w_next = (r_retry < c_RETRY_MAX) ? S_REQ : S_ERR;
        end
      end
      S_STREAM: begin
        CharValid = 1'b1;
        if (w_last_xfer) w_next = S_DONE;
      end
      S_DONE: begin
        Done = 1'b1;
        if (Start) w_next = S_REQ;
      end
      S_ERR: begin
        Error = 1'b1;
        if (Start) w_next = S_REQ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_word  <= 64'h0;
      r_count <= 5'd0;
      r_idx   <= 3'd0;
      r_len   <= 4'd0;
      r_tmo   <= '0;
      r_retry <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          r_tmo <= '0;
          r_idx <= 3'd0;
        end
        S_WAIT: begin
          if (Valid) begin
            r_word <= WordOut;
            r_len  <= w_len;
          end else if (w_tmo_hit) begin
            if (r_retry < c_RETRY_MAX) r_retry <= r_retry + 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_STREAM: begin
          if (CharReady) r_idx <= r_idx + 3'd1;
          // Index 7 wraps the character index to 0 on the same edge.
          if (w_last_xfer) begin
            r_count <= (r_count == c_CNT_LAST) ? 5'd0 : r_count + 5'd1;
            r_retry <= '0;
          end
        end
        S_ERR: begin
          if (Start) r_retry <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
